// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: queues commit-stage predictor updates and retires them to the BTB/PHT write ports,
// and runs a full-table invalidate sweep on flush. Define BP_UPD_BYPASS_EN for zero-latency writes.
module bp_update_ctrl #(
  parameter int BTB_INDEX_WIDTH = 4,
  parameter int PHT_INDEX_WIDTH = 6,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          upd_valid_i,
  output logic                          upd_ready_o,
  input  logic [BTB_INDEX_WIDTH-1:0]    upd_btb_index_i,
  input  logic [PHT_INDEX_WIDTH-1:0]    upd_pht_index_i,
  input  logic [30-BTB_INDEX_WIDTH-1:0] upd_tag_i,
  input  logic [31:0]                   upd_target_i,
  input  logic                          upd_btb_hit_i,
  input  logic                          upd_taken_i,
  input  logic                          upd_is_jmp_i,
  input  logic                          flush_req_i,
  output logic                          flush_busy_o,
  output logic                          flush_done_o,
  output logic                          pred_inhibit_o,
  output logic                          btb_wren_o,
  output logic [BTB_INDEX_WIDTH-1:0]    btb_wr_index_o,
  output logic [30-BTB_INDEX_WIDTH-1:0] btb_wr_tag_o,
  output logic [31:0]                   btb_wr_target_o,
  output logic                          btb_wr_valid_o,
  output logic                          pht_update_en_o,
  output logic [PHT_INDEX_WIDTH-1:0]    pht_wr_index_o,
  output logic                          pht_taken_o,
  output logic                          pht_clear_o
);
  localparam int TAG_W   = 30 - BTB_INDEX_WIDTH;
  localparam int SWEEP_W = (BTB_INDEX_WIDTH > PHT_INDEX_WIDTH) ? BTB_INDEX_WIDTH : PHT_INDEX_WIDTH;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  typedef struct packed {
    logic [BTB_INDEX_WIDTH-1:0] btb_index;
    logic [PHT_INDEX_WIDTH-1:0] pht_index;
    logic [TAG_W-1:0]           tag;
    logic [31:0]                target;
    logic                       btb_hit;
    logic                       taken;
  } entry_t;

  state_t             state_reg;
  logic [SWEEP_W-1:0] sweep_cnt_reg;
  logic               flush_done_reg;
  entry_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W:0]     count_reg;

  logic   idle, fifo_full, fifo_empty, accept, push, pop, bypass_fire, wr_active;
  logic   btb_in_range, pht_in_range;
  entry_t head, in_entry, wr_src;

  assign idle        = (state_reg == IDLE);
  assign fifo_full   = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty  = (count_reg == '0);
  assign upd_ready_o = idle & ~fifo_full & ~flush_req_i;
  assign accept      = upd_valid_i & upd_ready_o;

  assign in_entry = '{btb_index: upd_btb_index_i, pht_index: upd_pht_index_i, tag: upd_tag_i,
                      target: upd_target_i, btb_hit: upd_btb_hit_i, taken: upd_taken_i};
  assign head     = fifo_mem[rd_ptr_reg];

  // The sampled flush cycle must not write the tables, so retirement waits on flush_req_i too.
  assign pop = idle & ~flush_req_i & ~fifo_empty;

`ifdef BP_UPD_BYPASS_EN
  assign bypass_fire = accept & upd_is_jmp_i & fifo_empty;
`else
  assign bypass_fire = 1'b0;
`endif

  assign push      = accept & upd_is_jmp_i & ~bypass_fire;
  assign wr_active = pop | bypass_fire;
  assign wr_src    = pop ? head : in_entry;

  assign btb_in_range = ((sweep_cnt_reg >> BTB_INDEX_WIDTH) == '0);
  assign pht_in_range = ((sweep_cnt_reg >> PHT_INDEX_WIDTH) == '0);

  assign flush_busy_o   = ~idle;
  assign pred_inhibit_o = ~idle;
  assign flush_done_o   = flush_done_reg;

  always_comb begin
    btb_wren_o      = 1'b0;
    btb_wr_index_o  = '0;
    btb_wr_tag_o    = '0;
    btb_wr_target_o = '0;
    btb_wr_valid_o  = 1'b0;
    pht_update_en_o = 1'b0;
    pht_wr_index_o  = '0;
    pht_taken_o     = 1'b0;
    pht_clear_o     = 1'b0;
    if (!idle) begin
      btb_wren_o      = btb_in_range;
      btb_wr_index_o  = sweep_cnt_reg[BTB_INDEX_WIDTH-1:0];
      pht_update_en_o = pht_in_range;
      pht_clear_o     = pht_in_range;
      pht_wr_index_o  = sweep_cnt_reg[PHT_INDEX_WIDTH-1:0];
    end else if (wr_active) begin
      // Only jumps ever reach this path, so the PHT is always trained.
      btb_wren_o      = ~wr_src.btb_hit;
      btb_wr_index_o  = wr_src.btb_index;
      btb_wr_tag_o    = wr_src.tag;
      btb_wr_target_o = wr_src.target;
      btb_wr_valid_o  = 1'b1;
      pht_update_en_o = 1'b1;
      pht_wr_index_o  = wr_src.pht_index;
      pht_taken_o     = wr_src.taken;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      sweep_cnt_reg  <= '0;
      flush_done_reg <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
    end else begin
      flush_done_reg <= 1'b0;
      if (idle) begin
        if (flush_req_i) begin
          state_reg     <= SWEEP;
          sweep_cnt_reg <= '0;
          wr_ptr_reg    <= '0;
          rd_ptr_reg    <= '0;
          count_reg     <= '0;
        end else begin
          if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
          if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
          count_reg <= count_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
      end else begin
        sweep_cnt_reg <= sweep_cnt_reg + SWEEP_W'(1);
        if (sweep_cnt_reg == '1) begin
          state_reg      <= IDLE;
          flush_done_reg <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_reg] <= in_entry;
  end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Testbench for bp_update_ctrl: directed vector table, sweep/reset sequences, and random traffic
// checked against a queue-based reference model.
module tb_bp_update_ctrl;
  localparam int BIW = 4, PIW = 6, DEPTH = 4, TAGW = 30 - BIW, N = 64, NBTB = 16;
`ifdef BP_UPD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, upd_valid, upd_btb_hit, upd_taken, upd_is_jmp, flush_req;
  logic [BIW-1:0] upd_btb_index;
  logic [PIW-1:0] upd_pht_index;
  logic [TAGW-1:0] upd_tag;
  logic [31:0] upd_target;
  logic upd_ready_o, flush_busy_o, flush_done_o, pred_inhibit_o, btb_wren_o, btb_wr_valid_o;
  logic [BIW-1:0] btb_wr_index_o;
  logic [TAGW-1:0] btb_wr_tag_o;
  logic [31:0] btb_wr_target_o;
  logic pht_update_en_o, pht_taken_o, pht_clear_o;
  logic [PIW-1:0] pht_wr_index_o;

  bp_update_ctrl #(.BTB_INDEX_WIDTH(BIW), .PHT_INDEX_WIDTH(PIW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .upd_valid_i(upd_valid), .upd_ready_o(upd_ready_o),
    .upd_btb_index_i(upd_btb_index), .upd_pht_index_i(upd_pht_index), .upd_tag_i(upd_tag),
    .upd_target_i(upd_target), .upd_btb_hit_i(upd_btb_hit), .upd_taken_i(upd_taken),
    .upd_is_jmp_i(upd_is_jmp), .flush_req_i(flush_req), .flush_busy_o(flush_busy_o),
    .flush_done_o(flush_done_o), .pred_inhibit_o(pred_inhibit_o), .btb_wren_o(btb_wren_o),
    .btb_wr_index_o(btb_wr_index_o), .btb_wr_tag_o(btb_wr_tag_o), .btb_wr_target_o(btb_wr_target_o),
    .btb_wr_valid_o(btb_wr_valid_o), .pht_update_en_o(pht_update_en_o), .pht_wr_index_o(pht_wr_index_o),
    .pht_taken_o(pht_taken_o), .pht_clear_o(pht_clear_o)
  );

  int checks = 0, failures = 0;

  typedef struct {
    logic ready, busy, done, bwren, bval, pen, ptaken, clear;
    logic [BIW-1:0] bi;
    logic [TAGW-1:0] tag;
    logic [31:0] tgt;
    logic [PIW-1:0] pi;
  } exp_t;

  typedef struct {
    logic valid, jmp, hit, taken, flush;
    logic [BIW-1:0] bi;
    logic [PIW-1:0] pi;
    logic [31:0] tgt;
    logic e_ready, e_busy, e_done, e_bwren;
    logic [BIW-1:0] e_bi;
    logic [31:0] e_tgt;
    logic e_pen;
    logic [PIW-1:0] e_pi;
    logic e_taken, e_clear;
  } vec_t;

  typedef struct {
    logic [BIW-1:0] bi;
    logic [PIW-1:0] pi;
    logic [TAGW-1:0] tag;
    logic [31:0] tgt;
    logic hit, taken;
  } ent_t;

  function automatic logic [TAGW-1:0] tagf(input logic [31:0] t);
    return t[27:2] ^ 26'h0155;
  endfunction

  function automatic exp_t blank_exp();
    exp_t e;
    e.ready = 1'b0; e.busy = 1'b0; e.done = 1'b0; e.bwren = 1'b0; e.bval = 1'b0;
    e.pen = 1'b0; e.ptaken = 1'b0; e.clear = 1'b0; e.bi = '0; e.tag = '0; e.tgt = '0; e.pi = '0;
    return e;
  endfunction

  function automatic exp_t sweep_exp(input int i);
    exp_t e = blank_exp();
    e.busy = 1'b1; e.bwren = (i < NBTB); e.bi = BIW'(i % NBTB);
    e.pen = 1'b1; e.clear = 1'b1; e.pi = PIW'(i % N);
    return e;
  endfunction

  function automatic vec_t mk(input int v, j, h, tk, f, bi, pi, input logic [31:0] tgt,
                              input int er, eb, ed, ew, ebi, input logic [31:0] et,
                              input int ep, epi, etk, ec);
    vec_t r;
    r.valid = 1'(v); r.jmp = 1'(j); r.hit = 1'(h); r.taken = 1'(tk); r.flush = 1'(f);
    r.bi = BIW'(bi); r.pi = PIW'(pi); r.tgt = tgt;
    r.e_ready = 1'(er); r.e_busy = 1'(eb); r.e_done = 1'(ed); r.e_bwren = 1'(ew);
    r.e_bi = BIW'(ebi); r.e_tgt = et; r.e_pen = 1'(ep); r.e_pi = PIW'(epi);
    r.e_taken = 1'(etk); r.e_clear = 1'(ec);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h time=%0t", name, act, req, $time);
    end
  endtask

  task automatic check_out(input string nm, input exp_t e);
    chk({nm, ".ready"}, 64'(upd_ready_o), 64'(e.ready));
    chk({nm, ".busy"}, 64'(flush_busy_o), 64'(e.busy));
    chk({nm, ".inhibit"}, 64'(pred_inhibit_o), 64'(e.busy));
    chk({nm, ".done"}, 64'(flush_done_o), 64'(e.done));
    chk({nm, ".btb_wren"}, 64'(btb_wren_o), 64'(e.bwren));
    if (e.bwren) begin
      chk({nm, ".btb_idx"}, 64'(btb_wr_index_o), 64'(e.bi));
      chk({nm, ".btb_tag"}, 64'(btb_wr_tag_o), 64'(e.tag));
      chk({nm, ".btb_tgt"}, 64'(btb_wr_target_o), 64'(e.tgt));
      chk({nm, ".btb_val"}, 64'(btb_wr_valid_o), 64'(e.bval));
    end
    chk({nm, ".pht_en"}, 64'(pht_update_en_o), 64'(e.pen));
    if (e.pen) begin
      chk({nm, ".pht_idx"}, 64'(pht_wr_index_o), 64'(e.pi));
      chk({nm, ".pht_clr"}, 64'(pht_clear_o), 64'(e.clear));
      if (!e.clear) chk({nm, ".pht_tkn"}, 64'(pht_taken_o), 64'(e.ptaken));
    end
  endtask

  task automatic drive(input logic r, v, j, h, tk, f, input logic [BIW-1:0] bi,
                       input logic [PIW-1:0] pi, input logic [TAGW-1:0] tg, input logic [31:0] tgt);
    rst = r; upd_valid = v; upd_is_jmp = j; upd_btb_hit = h; upd_taken = tk; flush_req = f;
    upd_btb_index = bi; upd_pht_index = pi; upd_tag = tg; upd_target = tgt;
  endtask

  task automatic drive_idle(input logic f);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, f, '0, '0, '0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[12];
  ent_t q[$];

  initial begin
    exp_t e;
    int msweep, done_cnt;
    bit mdone, acc;
    vec_t v;
    ent_t ne;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    tick(); tick();
    drive_idle(1'b0);

    tbl[0]  = mk(0,0,0,0,0, 0,0,0,          1,0,0,0, 0,0,        0,0,0,0);
`ifdef BP_UPD_BYPASS_EN
    tbl[1]  = mk(1,1,0,1,0, 3,10,32'h80,    1,0,0,1, 3,32'h80,   1,10,1,0);
    tbl[2]  = mk(0,0,0,0,0, 0,0,0,          1,0,0,0, 0,0,        0,0,0,0);
    tbl[6]  = mk(1,1,1,0,0, 7,20,32'h200,   1,0,0,0, 0,0,        1,20,0,0);
    tbl[7]  = mk(1,1,0,1,0, 2,33,32'h300,   1,0,0,1, 2,32'h300,  1,33,1,0);
`else
    tbl[1]  = mk(1,1,0,1,0, 3,10,32'h80,    1,0,0,0, 0,0,        0,0,0,0);
    tbl[2]  = mk(0,0,0,0,0, 0,0,0,          1,0,0,1, 3,32'h80,   1,10,1,0);
    tbl[6]  = mk(1,1,1,0,0, 7,20,32'h200,   1,0,0,0, 0,0,        0,0,0,0);
    tbl[7]  = mk(1,1,0,1,0, 2,33,32'h300,   1,0,0,0, 0,0,        1,20,0,0);
`endif
    tbl[3]  = mk(0,0,0,0,0, 0,0,0,          1,0,0,0, 0,0,        0,0,0,0);
    tbl[4]  = mk(1,0,0,1,0, 5,11,32'h100,   1,0,0,0, 0,0,        0,0,0,0);
    tbl[5]  = mk(0,0,0,0,0, 0,0,0,          1,0,0,0, 0,0,        0,0,0,0);
    tbl[8]  = mk(1,1,0,1,1, 9,40,32'h400,   0,0,0,0, 0,0,        0,0,0,0);
    tbl[9]  = mk(0,0,0,0,0, 0,0,0,          0,1,0,1, 0,0,        1,0,0,1);
    tbl[10] = mk(0,0,0,0,1, 0,0,0,          0,1,0,1, 1,0,        1,1,0,1);
    tbl[11] = mk(1,1,0,1,0, 1,1,32'h500,    0,1,0,1, 2,0,        1,2,0,1);

    // Directed vectors: reset state, single update, non-jump, back-to-back, flush-vs-update, sweep start.
    for (int i = 0; i < 12; i++) begin
      v = tbl[i];
      drive(1'b0, v.valid, v.jmp, v.hit, v.taken, v.flush, v.bi, v.pi, tagf(v.tgt), v.tgt);
      @(negedge clk);
      e = blank_exp();
      e.ready = v.e_ready; e.busy = v.e_busy; e.done = v.e_done; e.bwren = v.e_bwren;
      e.bi = v.e_bi; e.bval = v.e_bwren & ~v.e_busy;
      e.tgt = v.e_busy ? 32'h0 : v.e_tgt;
      e.tag = v.e_busy ? '0 : tagf(v.e_tgt);
      e.pen = v.e_pen; e.pi = v.e_pi; e.ptaken = v.e_taken; e.clear = v.e_clear;
      check_out($sformatf("vec%0d", i), e);
      $display("VEC %0d valid=%0b jmp=%0b flush=%0b btb=%0d pht=%0d", i, v.valid, v.jmp, v.flush, v.bi, v.pi);
      tick();
    end

    // Remainder of the sweep, flush held for a while to show it does not restart.
    for (int i = 3; i < N; i++) begin
      drive_idle(i < 30);
      @(negedge clk);
      check_out($sformatf("sweep%0d", i), sweep_exp(i));
      tick();
    end
    drive_idle(1'b0);
    @(negedge clk);
    e = blank_exp(); e.ready = 1'b1; e.done = 1'b1;
    check_out("sweep_done", e);
    $display("SWEEP complete, done pulse checked");
    tick();
    @(negedge clk);
    e.done = 1'b0;
    check_out("after_done", e);
    tick();

    // Reset while the sweep is at index 20: abandoned, done never pulses.
    drive_idle(1'b1);
    @(negedge clk);
    tick();
    drive_idle(1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_out($sformatf("rsweep%0d", i), sweep_exp(i));
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    check_out("rsweep20", sweep_exp(20));
    tick();
    drive_idle(1'b0);
    @(negedge clk);
    e = blank_exp(); e.ready = 1'b1;
    check_out("after_rst", e);
    done_cnt = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (flush_done_o) done_cnt++;
      tick();
    end
    chk("no_done_after_rst", 64'(done_cnt), 64'd0);
    $display("RESET mid-sweep sequence complete");

    // Random traffic against a queue model.
    msweep = -1; mdone = 1'b0;
    for (int c = 0; c < 500; c++) begin
      drive(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            (msweep >= 0) ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 59) == 0),
            BIW'($urandom), PIW'($urandom), TAGW'($urandom), $urandom);
      e = blank_exp();
      e.done = mdone;
      e.ready = (msweep < 0) && (q.size() < DEPTH) && !flush_req;
      acc = upd_valid && e.ready;
      ne.bi = upd_btb_index; ne.pi = upd_pht_index; ne.tag = upd_tag; ne.tgt = upd_target;
      ne.hit = upd_btb_hit; ne.taken = upd_taken;
      if (msweep >= 0) begin
        e = sweep_exp(msweep);
        e.done = mdone;
      end else if (!flush_req && (q.size() > 0 || (BYPASS && acc && upd_is_jmp))) begin
        ent_t w;
        w = (q.size() > 0) ? q[0] : ne;
        e.bwren = ~w.hit; e.bi = w.bi; e.tag = w.tag; e.tgt = w.tgt; e.bval = 1'b1;
        e.pen = 1'b1; e.pi = w.pi; e.ptaken = w.taken; e.clear = 1'b0;
      end
      @(negedge clk);
      check_out($sformatf("rnd%0d", c), e);
      if (acc) $display("TXN %0d upd jmp=%0b hit=%0b taken=%0b btb=%0d pht=%0d", c, upd_is_jmp,
                        upd_btb_hit, upd_taken, upd_btb_index, upd_pht_index);
      if (rst) begin
        q.delete(); msweep = -1; mdone = 1'b0;
      end else if (msweep >= 0) begin
        if (msweep == N - 1) begin msweep = -1; mdone = 1'b1; end
        else begin msweep++; mdone = 1'b0; end
      end else begin
        mdone = 1'b0;
        if (flush_req) begin
          q.delete(); msweep = 0;
        end else begin
          bit was_empty;
          was_empty = (q.size() == 0);
          if (!was_empty) void'(q.pop_front());
          if (acc && upd_is_jmp && !(BYPASS && was_empty)) q.push_back(ne);
        end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
